xm_latch_md: RTL and testbench
==============================

Name: xm_latch_md

Overview:
- X/M pipeline register that sits directly downstream of the D/X latch.
- Captures the execute-stage PC, instruction, ALU result and B operand for the memory stage.
- Sequences multi-cycle mult/div operations: issues a start pulse, stalls the upstream stages, and injects bubbles into M until the multdiv unit reports ready. It then writes the multdiv result in place of the ALU result.

Parameters:
- WIDTH, 32, datapath width of PC, instruction, result and operand fields.
- NOP_INS, 32'h0000_0000, instruction word injected into M as a bubble.
- MD_MAX_CYCLES, 40, BUSY cycle limit; used only when the optional feature is enabled.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inPc  in  WIDTH  PC of the instruction in X
- inIns  in  WIDTH  instruction in X
- aluResult  in  WIDTH  ALU output for the instruction in X
- b_in  in  WIDTH  B operand from X (store data)
- aluOvf  in  1  ALU overflow for the instruction in X
- isMd  in  1  instruction in X is mul or div (decoded upstream)
- mdReady  in  1  multdiv result valid (data_resultRDY)
- mdResult  in  WIDTH  multdiv result
- mdExc  in  1  multdiv exception (divide-by-zero / overflow)
- mdStart  out  1  one-cycle start pulse to the multdiv unit
- stall  out  1  freezes PC, F/D and D/X while high (combinational)
- pcOut  out  WIDTH  registered PC to M
- insOut  out  WIDTH  registered instruction to M
- oOut  out  WIDTH  registered result (ALU or multdiv) to M
- bOut  out  WIDTH  registered B operand to M
- excOut  out  1  registered exception flag to M

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - pcOut, oOut and bOut = 0; insOut = NOP_INS; excOut = 0.
  - mdStart = 0; stall = 0.
- States: IDLE, BUSY (2-bit encoding, with spare codes).
- IDLE, isMd=0:
  - Every edge loads pcOut<=inPc, insOut<=inIns, oOut<=aluResult, bOut<=b_in, excOut<=aluOvf.
  - Latency is 1 cycle.
- IDLE, isMd=1:
  - mdStart=1 and stall=1 (both combinational) in that cycle.
  - On the edge: state->BUSY, and the latch loads a bubble (insOut=NOP_INS; pcOut, oOut, bOut, excOut = 0).
- BUSY:
  - mdStart=0 and stall=!mdReady.
  - The D/X latch is frozen, so inIns and inPc still present the md instruction.
  - mdReady=0: load a bubble and remain in BUSY.
  - mdReady=1: load pcOut<=inPc, insOut<=inIns, oOut<=mdResult, bOut<=b_in, excOut<=mdExc; state->IDLE.
  - Because stall drops in that same cycle, upstream advances on the same edge.
- mdReady while in IDLE: ignored.
- aluOvf while in BUSY: ignored.
- Back-to-back md instructions: the second md instruction is in X during the cycle after completion. It re-enters IDLE with isMd=1 and starts a new pulse. No md instruction is lost or duplicated.
- mdStart is asserted for exactly one cycle per md instruction.
- Reset during BUSY: immediate return to IDLE, stall drops, bubble outputs. A late mdReady is ignored.
- Spare state codes: treated as IDLE on the next edge.

Optional Feature:
- Macro: XM_MD_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on IDLE->BUSY and increments each BUSY cycle.
  - If the counter reaches MD_MAX_CYCLES with mdReady=0, the latch loads insOut<=inIns, pcOut<=inPc, oOut<=0, excOut<=1, and state->IDLE. stall=0 in that cycle.
- Undefined: no counter exists; BUSY waits for mdReady indefinitely.

Decomposition:
- Shared package xm_pkg:
  - state encodings (ST_IDLE, ST_BUSY)
  - NOP_INS default
  - WIDTH default
  - timeout counter width
- One sub-module, md_seq: the IDLE/BUSY FSM plus the optional timeout counter.
  - Outputs: mdStart, stall, selMd (write multdiv result), selBubble.
- The top-level module holds the per-bit dffe_ref registers and the result/bubble muxing.

Test Plan:
- Reset pulse with all inputs nonzero -> insOut=0, oOut=0, excOut=0, stall=0 immediately, before any clock edge.
- ALU instruction: inPc=5, inIns=32'h0084_1800, aluResult=32'h1234, isMd=0 -> all four outputs match one edge later; stall stays 0.
- mul with mdReady raised 3 cycles after mdStart, mdResult=32'd42 -> mdStart high for 1 cycle, stall high for 4 cycles, 4 bubbles in M, then oOut=42 with insOut=the mul instruction.
- Two consecutive div instructions, each completing in 2 cycles -> 2 distinct mdStart pulses and 2 results in M, in order.
- reset asserted mid-BUSY, then mdReady=1 -> state IDLE, stall=0, and no result written.
- With XM_MD_TIMEOUT_EN defined, MD_MAX_CYCLES=4 and mdReady held 0 -> excOut=1 and oOut=0 after 4 BUSY cycles, and stall releases.

Source files
------------

// File: rtl/xm_pkg.sv
// Shared definitions for the X/M pipeline latch and its mult/div sequencer.
// Optional feature macro: XM_MD_TIMEOUT_EN (bounded BUSY wait, see md_seq).
package xm_pkg;

  // Default datapath width of the PC, instruction, result and operand fields.
  localparam int XM_WIDTH = 32;

  // Instruction word placed into M when a bubble is injected.
  localparam logic [31:0] XM_NOP_INS = 32'h0000_0000;

  // Width of the BUSY-cycle counter used by the optional timeout.
  localparam int TMO_CNT_W = 8;

  // Sequencer states. Codes 2'b10 and 2'b11 are spare and recover to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } md_state_t;

endpackage

// File: rtl/md_seq.sv
// Mult/div sequencer: IDLE/BUSY FSM that issues the start pulse, holds the
// upstream stages and tells the latch whether to load a bubble, the multdiv
// result or a timed-out exception word.
// Optional feature macro: XM_MD_TIMEOUT_EN adds a BUSY-cycle limit.
module md_seq
  import xm_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      isMd,
  input  logic      mdReady,
  output logic      mdStart,
  output logic      stall,
  output logic      selMd,
  output logic      selBubble,
  output logic      selTimeout,
  output md_state_t state
);

  md_state_t state_next;
  logic      tmo_hit;

`ifdef XM_MD_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] busy_cnt;

  // Counts completed BUSY cycles; cleared when a new mult/div is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (state == ST_IDLE && state_next == ST_BUSY) begin
      busy_cnt <= '0;
    end else if (state == ST_BUSY) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  // The MD_MAX_CYCLES-th BUSY cycle without a ready gives up.
  assign tmo_hit = (busy_cnt == TMO_CNT_W'(MD_MAX_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (MD_MAX_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. During reset the start pulse and the
  // stall are forced low so upstream is never frozen by stale inputs.
  always_comb begin
    state_next = state;
    mdStart    = 1'b0;
    stall      = 1'b0;
    selMd      = 1'b0;
    selBubble  = 1'b0;
    selTimeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (isMd) begin
          mdStart    = 1'b1;
          stall      = 1'b1;
          selBubble  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mdReady) begin
          selMd      = 1'b1;
          state_next = ST_IDLE;
        end else if (tmo_hit) begin
          selTimeout = 1'b1;
          state_next = ST_IDLE;
        end else begin
          stall      = 1'b1;
          selBubble  = 1'b1;
        end
      end
      default: begin
        selBubble  = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
    if (rst) begin
      mdStart = 1'b0;
      stall   = 1'b0;
    end
  end

endmodule

// File: rtl/xm_latch_md.sv
// X/M pipeline register. Captures PC, instruction, result and B operand for
// the memory stage, and substitutes bubbles / the multdiv result while a
// mult/div instruction is sequenced by md_seq.
// Optional feature macro: XM_MD_TIMEOUT_EN (BUSY timeout, loads excOut=1).
module xm_latch_md
  import xm_pkg::*;
#(
  parameter int               WIDTH         = XM_WIDTH,
  parameter logic [WIDTH-1:0] NOP_INS       = XM_NOP_INS,
  parameter int               MD_MAX_CYCLES = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inPc,
  input  logic [WIDTH-1:0] inIns,
  input  logic [WIDTH-1:0] aluResult,
  input  logic [WIDTH-1:0] b_in,
  input  logic             aluOvf,
  input  logic             isMd,
  input  logic             mdReady,
  input  logic [WIDTH-1:0] mdResult,
  input  logic             mdExc,
  output logic             mdStart,
  output logic             stall,
  output logic [WIDTH-1:0] pcOut,
  output logic [WIDTH-1:0] insOut,
  output logic [WIDTH-1:0] oOut,
  output logic [WIDTH-1:0] bOut,
  output logic             excOut
);

  logic      sel_md;
  logic      sel_bubble;
  logic      sel_timeout;
  md_state_t unused_md_state;

  logic [WIDTH-1:0] o_next;
  logic             exc_next;

  md_seq #(
    .MD_MAX_CYCLES (MD_MAX_CYCLES)
  ) u_md_seq (
    .clk        (clk),
    .rst        (reset),
    .isMd       (isMd),
    .mdReady    (mdReady),
    .mdStart    (mdStart),
    .stall      (stall),
    .selMd      (sel_md),
    .selBubble  (sel_bubble),
    .selTimeout (sel_timeout),
    .state      (unused_md_state)
  );

  // Result/exception source: multdiv, timeout word, or the ALU.
  always_comb begin
    o_next   = aluResult;
    exc_next = aluOvf;
    if (sel_md) begin
      o_next   = mdResult;
      exc_next = mdExc;
    end else if (sel_timeout) begin
      o_next   = '0;
      exc_next = 1'b1;
    end
  end

  // Pipeline register: bubble while the sequencer holds, otherwise load X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcOut  <= '0;
      insOut <= NOP_INS;
      oOut   <= '0;
      bOut   <= '0;
      excOut <= 1'b0;
    end else if (sel_bubble) begin
      pcOut  <= '0;
      insOut <= NOP_INS;
      oOut   <= '0;
      bOut   <= '0;
      excOut <= 1'b0;
    end else begin
      pcOut  <= inPc;
      insOut <= inIns;
      oOut   <= o_next;
      bOut   <= b_in;
      excOut <= exc_next;
    end
  end

endmodule

// File: tb/tb_xm_latch_md.sv
// Directed bench for xm_latch_md: ALU pass-through, mult/div sequencing,
// back-to-back mult/div, reset during BUSY, and (with XM_MD_TIMEOUT_EN)
// the BUSY timeout.
module tb_xm_latch_md;

  localparam int W = 32;
  localparam int VW = 4 * W + 1;
  localparam logic [W-1:0] NOP = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] inPc, inIns, aluResult, b_in, mdResult;
  logic         aluOvf, isMd, mdReady, mdExc;
  logic         mdStart, stall, excOut;
  logic [W-1:0] pcOut, insOut, oOut, bOut;

  logic [VW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  xm_latch_md #(
    .WIDTH         (W),
    .NOP_INS       (NOP),
    .MD_MAX_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inPc      (inPc),
    .inIns     (inIns),
    .aluResult (aluResult),
    .b_in      (b_in),
    .aluOvf    (aluOvf),
    .isMd      (isMd),
    .mdReady   (mdReady),
    .mdResult  (mdResult),
    .mdExc     (mdExc),
    .mdStart   (mdStart),
    .stall     (stall),
    .pcOut     (pcOut),
    .insOut    (insOut),
    .oOut      (oOut),
    .bOut      (bOut),
    .excOut    (excOut)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack(input logic [W-1:0] pc, input logic [W-1:0] ins,
                                         input logic [W-1:0] o, input logic [W-1:0] b,
                                         input logic exc);
    return {pc, ins, o, b, exc};
  endfunction

  function automatic logic [VW-1:0] bubble();
    return {32'h0, NOP, 32'h0, 32'h0, 1'b0};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [VW-1:0] exp);
    logic [VW-1:0] obs;
    obs = {pcOut, insOut, oOut, bOut, excOut};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed pc=%h ins=%h o=%h b=%h exc=%b expected pc=%h ins=%h o=%h b=%h exc=%b",
             tag, obs[VW-1 -: W], obs[VW-W-1 -: W], obs[2*W : W+1], obs[W:1], obs[0],
             exp[VW-1 -: W], exp[VW-W-1 -: W], exp[2*W : W+1], exp[W:1], exp[0]);
    end
  endtask

  // One clock: check combinational controls, push expectation, clock, pop/compare.
  task automatic cycle(input string tag, input logic exp_stall, input logic exp_start,
                       input logic [VW-1:0] exp);
    logic [VW-1:0] e;
    #1;
    check_bit({tag, ".stall"}, stall, exp_stall);
    check_bit({tag, ".mdStart"}, mdStart, exp_start);
    if (mdStart) start_cnt++;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_out({tag, ".out"}, e);
    end
  endtask

  task automatic drive(input logic [W-1:0] pc, input logic [W-1:0] ins, input logic [W-1:0] alu,
                       input logic [W-1:0] b, input logic ovf, input logic md);
    inPc = pc; inIns = ins; aluResult = alu; b_in = b; aluOvf = ovf; isMd = md;
  endtask

  initial begin
    logic [W-1:0] mul_ins, div1, div2;
    mul_ins = 32'h0022_0030;
    div1    = 32'h0043_1038;
    div2    = 32'h0065_2038;

    // Reset with all inputs nonzero: outputs must be clean before any edge.
    reset = 1'b1;
    drive(32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
    mdReady = 1'b1; mdResult = 32'h3333_3333; mdExc = 1'b1;
    #1;
    check_bit("rst.stall", stall, 1'b0);
    check_bit("rst.mdStart", mdStart, 1'b0);
    check_out("rst.out", bubble());
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_out("rst.hold", bubble());
    reset = 1'b0;

    // ALU instructions; mdReady high in IDLE must be ignored.
    drive(32'd5, 32'h0084_1800, 32'h1234, 32'd77, 1'b0, 1'b0);
    cycle("alu0", 1'b0, 1'b0, pack(32'd5, 32'h0084_1800, 32'h1234, 32'd77, 1'b0));
    drive(32'd6, 32'h0001_0002, 32'h7FFF_FFFF, 32'd9, 1'b1, 1'b0);
    cycle("alu1", 1'b0, 1'b0, pack(32'd6, 32'h0001_0002, 32'h7FFF_FFFF, 32'd9, 1'b1));

    // mul: start, 3 more busy cycles (aluOvf ignored), then result 42.
    start_cnt = 0;
    drive(32'd8, mul_ins, 32'd999, 32'd3, 1'b1, 1'b1);
    mdReady = 1'b0; mdResult = 32'd42; mdExc = 1'b0;
    cycle("mul.c1", 1'b1, 1'b1, bubble());
    cycle("mul.c2", 1'b1, 1'b0, bubble());
    cycle("mul.c3", 1'b1, 1'b0, bubble());
    cycle("mul.c4", 1'b1, 1'b0, bubble());
    mdReady = 1'b1;
    cycle("mul.done", 1'b0, 1'b0, pack(32'd8, mul_ins, 32'd42, 32'd3, 1'b0));
    checks++;
    assert (start_cnt === 1) else begin
      errors++;
      $error("FAIL mul.pulses observed=%0d expected=1", start_cnt);
    end

    // Two back-to-back divs, each completing on its second BUSY-side cycle.
    start_cnt = 0;
    drive(32'd12, div1, 32'd1, 32'd4, 1'b0, 1'b1);
    mdReady = 1'b0; mdResult = 32'd100; mdExc = 1'b0;
    cycle("div1.c1", 1'b1, 1'b1, bubble());
    cycle("div1.c2", 1'b1, 1'b0, bubble());
    mdReady = 1'b1;
    cycle("div1.done", 1'b0, 1'b0, pack(32'd12, div1, 32'd100, 32'd4, 1'b0));
    drive(32'd16, div2, 32'd2, 32'd5, 1'b0, 1'b1);
    mdResult = 32'd200; mdExc = 1'b1;
    cycle("div2.c1", 1'b1, 1'b1, bubble());
    mdReady = 1'b0;
    cycle("div2.c2", 1'b1, 1'b0, bubble());
    mdReady = 1'b1;
    cycle("div2.done", 1'b0, 1'b0, pack(32'd16, div2, 32'd200, 32'd5, 1'b1));
    checks++;
    assert (start_cnt === 2) else begin
      errors++;
      $error("FAIL div.pulses observed=%0d expected=2", start_cnt);
    end
    drive(32'd20, 32'h0000_00AA, 32'd55, 32'd6, 1'b0, 1'b0);
    cycle("post_div", 1'b0, 1'b0, pack(32'd20, 32'h0000_00AA, 32'd55, 32'd6, 1'b0));

    // Reset mid-BUSY, then a late mdReady must not write a result.
    drive(32'd24, mul_ins, 32'd7, 32'd8, 1'b0, 1'b1);
    mdReady = 1'b0; mdResult = 32'hBAD0_BAD0; mdExc = 1'b1;
    cycle("rb.c1", 1'b1, 1'b1, bubble());
    cycle("rb.c2", 1'b1, 1'b0, bubble());
    reset = 1'b1;
    mdReady = 1'b1;
    #1;
    check_bit("rb.rst.stall", stall, 1'b0);
    check_out("rb.rst.out", bubble());
    @(posedge clk); #1;
    reset = 1'b0;
    drive(32'd28, 32'h0000_0BBB, 32'd66, 32'd10, 1'b0, 1'b0);
    cycle("rb.after", 1'b0, 1'b0, pack(32'd28, 32'h0000_0BBB, 32'd66, 32'd10, 1'b0));

`ifdef XM_MD_TIMEOUT_EN
    // Timeout with MD_MAX_CYCLES=4 and mdReady held low.
    drive(32'd32, div1, 32'd9, 32'd11, 1'b0, 1'b1);
    mdReady = 1'b0; mdResult = 32'd123; mdExc = 1'b0;
    cycle("tmo.c0", 1'b1, 1'b1, bubble());
    cycle("tmo.b1", 1'b1, 1'b0, bubble());
    cycle("tmo.b2", 1'b1, 1'b0, bubble());
    cycle("tmo.b3", 1'b1, 1'b0, bubble());
    cycle("tmo.b4", 1'b0, 1'b0, pack(32'd32, div1, 32'd0, 32'd11, 1'b1));
    drive(32'd36, 32'h0000_0CCC, 32'd77, 32'd12, 1'b0, 1'b0);
    cycle("tmo.after", 1'b0, 1'b0, pack(32'd36, 32'h0000_0CCC, 32'd77, 32'd12, 1'b0));
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue.drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
